// File: rtl/stage_sequencer.sv
// stage_sequencer: multicycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer.
// The sequencer gates the control unit's level signals so that they act only in
// the correct stage. It walks each instruction through only the stages that its
// class needs.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// IDLE    0  | parked, waits for run
// FETCH   1  | memory read of the next word, MEM_WAIT+1 cycles, IR load on last
// DECODE  2  | classify instruction[31:29]; illegal encodings go to TRAP
// EXECUTE 3  | one cycle; NOP and control transfers (except jal) retire here
// MEMORY  4  | load/store access, MEM_WAIT+1 cycles; a store retires on the last
// WRITEBACK 5| register-file write, retire
// TRAP    7  | halted until reset
//
// Every output is decoded from registered state only, so an asynchronous reset
// releases the memory gates immediately.
module stage_sequencer #(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] instruction,
    output logic        irWrite,
    output logic        pcWrite,
    output logic        regWriteEnable,
    output logic        memReadGate,
    output logic        memWriteGate,
    output logic [2:0]  stage,
    output logic        halted,
    output logic [15:0] instrCount
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_TRAP      = 3'd7
    } state_t;

    // C_EXEC: retires in EXECUTE (nop, jump, beq, bne, jr)
    // C_WB:   goes through WRITEBACK (alu, constant, jal)
    typedef enum logic [1:0] {
        C_EXEC  = 2'd0,
        C_WB    = 2'd1,
        C_LOAD  = 2'd2,
        C_STORE = 2'd3
    } cls_t;

    localparam logic [2:0] WAIT_LAST = 3'(MEM_WAIT);

    state_t      state_q, state_d;
    cls_t        cls_q, cls_d;
    logic [2:0]  wait_q, wait_d;
    logic [15:0] count_q, count_d;

    cls_t        dec_cls;
    logic        dec_legal;
    logic        wait_last;
    logic        retire;

    // Only the class and sub-opcode fields matter to sequencing.
    logic        unused_instr_bits;
    assign unused_instr_bits = ^{instruction[25], instruction[23:0]};

    // Classify the opcode field and flag illegal encodings.
    always_comb begin
        dec_cls   = C_EXEC;
        dec_legal = 1'b1;
        case (instruction[31:29])
            3'b000:         dec_cls = C_EXEC;
            3'b001, 3'b010: dec_cls = C_WB;
            3'b100:         dec_cls = instruction[24] ? C_STORE : C_LOAD;
            3'b101: begin
                if (instruction[28:26] > 3'b100) begin
                    dec_legal = 1'b0;
                end else if (instruction[28:26] == 3'b011) begin
                    dec_cls = C_WB;
                end else begin
                    dec_cls = C_EXEC;
                end
            end
            default:        dec_legal = 1'b0;
        endcase
    end

    assign wait_last = (wait_q == WAIT_LAST);

    assign retire = ((state_q == S_EXECUTE) && (cls_q == C_EXEC))
                  || ((state_q == S_MEMORY) && (cls_q == C_STORE) && wait_last)
                  || (state_q == S_WRITEBACK);

    // Next state, wait counter, latched class and retire counter.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        wait_d  = wait_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (wait_last) begin
                    wait_d  = 3'd0;
                    state_d = S_DECODE;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    cls_d   = dec_cls;
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_EXECUTE: begin
                if (cls_q == C_LOAD || cls_q == C_STORE) begin
                    state_d = S_MEMORY;
                end else if (cls_q == C_WB) begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (wait_last) begin
                    wait_d = 3'd0;
                    if (cls_q == C_LOAD) state_d = S_WRITEBACK;
                end else begin
                    wait_d = wait_q + 3'd1;
                end
            end
            S_WRITEBACK: ;
            S_TRAP:      ;
            default: begin
                state_d = S_IDLE;
                wait_d  = 3'd0;
            end
        endcase
        // The retire cycle overrides the per-state choice of successor.
        if (retire) begin
            count_d = count_q + 16'd1;
            state_d = run ? S_FETCH : S_IDLE;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cls_q   <= C_EXEC;
            wait_q  <= 3'd0;
            count_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            wait_q  <= wait_d;
            count_q <= count_d;
        end
    end

    // Output decode of registered state.
    always_comb begin
        irWrite        = (state_q == S_FETCH) && wait_last;
        pcWrite        = retire;
        regWriteEnable = (state_q == S_WRITEBACK);
        memReadGate    = !((state_q == S_FETCH)
                        || ((state_q == S_MEMORY) && (cls_q == C_LOAD)));
        memWriteGate   = !((state_q == S_MEMORY) && (cls_q == C_STORE));
        stage          = state_q;
        halted         = (state_q == S_TRAP);
        instrCount     = count_q;
    end

endmodule

// File: tb/tb_stage_sequencer.sv
// Testbench for stage_sequencer: directed instruction traces with expected
// per-cycle outputs queued by the stimulus and compared by a negedge monitor.
module tb_stage_sequencer;

    localparam logic [31:0] I_ADD = 32'h2000_0000;
    localparam logic [31:0] I_LD  = 32'h8000_0000;
    localparam logic [31:0] I_ST  = 32'h8100_0000;
    localparam logic [31:0] I_BEQ = 32'hA400_0000;
    localparam logic [31:0] I_NOP = 32'h0000_0000;
    localparam logic [31:0] I_TRP = 32'hE000_0000;
    localparam logic [31:0] I_BAD = 32'hB400_0000;
    localparam logic [31:0] I_JAL = 32'hAC00_0000;
    localparam logic [31:0] I_JR  = 32'hB000_0000;

    typedef struct packed {
        logic        sel;
        logic [15:0] id;
        logic [2:0]  st;
        logic        ir, pc, rw, mr, mw, h;
        logic [15:0] cnt;
    } rec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        run, run0;
    logic [31:0] instruction, instruction0;

    logic        irWrite, pcWrite, regWriteEnable, memReadGate, memWriteGate, halted;
    logic [2:0]  stage;
    logic [15:0] instrCount;
    logic        irWrite0, pcWrite0, regWriteEnable0, memReadGate0, memWriteGate0, halted0;
    logic [2:0]  stage0;
    logic [15:0] instrCount0;

    int   checks = 0;
    int   errors = 0;
    int   step_id = 0;
    rec_t exp_q[$];

    always #5 clock = ~clock;

    stage_sequencer #(.MEM_WAIT(1)) u_dut (
        .clock(clock), .reset(reset), .run(run), .instruction(instruction),
        .irWrite(irWrite), .pcWrite(pcWrite), .regWriteEnable(regWriteEnable),
        .memReadGate(memReadGate), .memWriteGate(memWriteGate), .stage(stage),
        .halted(halted), .instrCount(instrCount)
    );

    stage_sequencer #(.MEM_WAIT(0)) u_dut0 (
        .clock(clock), .reset(reset), .run(run0), .instruction(instruction0),
        .irWrite(irWrite0), .pcWrite(pcWrite0), .regWriteEnable(regWriteEnable0),
        .memReadGate(memReadGate0), .memWriteGate(memWriteGate0), .stage(stage0),
        .halted(halted0), .instrCount(instrCount0)
    );

    // Monitor: pop one expected record per cycle and compare the selected DUT.
    always @(negedge clock) begin
        if (exp_q.size() != 0) begin
            rec_t e, o;
            e = exp_q.pop_front();
            o = '0;
            o.sel = e.sel;
            o.id  = e.id;
            if (!e.sel) begin
                o.st = stage;  o.ir = irWrite;  o.pc = pcWrite;  o.rw = regWriteEnable;
                o.mr = memReadGate;  o.mw = memWriteGate;  o.h = halted;  o.cnt = instrCount;
            end else begin
                o.st = stage0; o.ir = irWrite0; o.pc = pcWrite0; o.rw = regWriteEnable0;
                o.mr = memReadGate0; o.mw = memWriteGate0; o.h = halted0; o.cnt = instrCount0;
            end
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL trace dut%0d step %0d: got st=%0d ir=%b pc=%b rw=%b mr=%b mw=%b h=%b cnt=%0d, expected st=%0d ir=%b pc=%b rw=%b mr=%b mw=%b h=%b cnt=%0d",
                         e.sel ? 0 : 1, e.id, o.st, o.ir, o.pc, o.rw, o.mr, o.mw, o.h, o.cnt,
                         e.st, e.ir, e.pc, e.rw, e.mr, e.mw, e.h, e.cnt);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic push(input logic s, input logic [2:0] st, input logic ir, input logic pc,
                        input logic rw, input logic mr, input logic mw, input logic h,
                        input logic [15:0] c);
        rec_t r;
        r.sel = s; r.id = 16'(step_id); r.st = st;
        r.ir = ir; r.pc = pc; r.rw = rw; r.mr = mr; r.mw = mw; r.h = h; r.cnt = c;
        exp_q.push_back(r);
        step_id++;
    endtask

    // One cycle on the MEM_WAIT=1 instance: drive inputs, queue expected outputs.
    task automatic step(input logic r, input logic [31:0] ins, input logic [2:0] st,
                        input logic ir, input logic pc, input logic rw, input logic mr,
                        input logic mw, input logic h, input logic [15:0] c);
        run = r;
        instruction = ins;
        push(1'b0, st, ir, pc, rw, mr, mw, h, c);
        @(posedge clock);
        #1;
    endtask

    // One cycle on the MEM_WAIT=0 instance.
    task automatic step0(input logic r, input logic [31:0] ins, input logic [2:0] st,
                         input logic ir, input logic pc, input logic rw, input logic mr,
                         input logic mw, input logic h, input logic [15:0] c);
        run0 = r;
        instruction0 = ins;
        push(1'b1, st, ir, pc, rw, mr, mw, h, c);
        @(posedge clock);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, " stage"}, 32'(stage), 32'd0);
        chk({tag, " halted"}, 32'(halted), 32'd0);
        chk({tag, " instrCount"}, 32'(instrCount), 32'd0);
        chk({tag, " gates/enables"},
            32'({irWrite, pcWrite, regWriteEnable, memReadGate, memWriteGate}), 32'b00011);
    endtask

    task automatic pulse_reset(input string tag);
        run = 1'b0;
        run0 = 1'b0;
        reset = 1'b0;
        #1;
        reset_checks(tag);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        run = 1'b0;
        run0 = 1'b0;
        instruction = 32'h0;
        instruction0 = 32'h0;
        #3;
        reset_checks("power-on reset");
        #9;
        reset = 1'b1;
        @(posedge clock);
        #1;

        // add (5 cycles), load (7), store (6) back to back, run dropped at store retire
        //      run ins    st ir pc rw mr mw h cnt
        step(1, I_ADD, 0, 0, 0, 0, 1, 1, 0, 0);
        step(1, I_ADD, 1, 0, 0, 0, 0, 1, 0, 0);
        step(1, I_ADD, 1, 1, 0, 0, 0, 1, 0, 0);
        step(1, I_ADD, 2, 0, 0, 0, 1, 1, 0, 0);
        step(1, I_ADD, 3, 0, 0, 0, 1, 1, 0, 0);
        step(1, I_ADD, 5, 0, 1, 1, 1, 1, 0, 0);
        step(1, I_LD,  1, 0, 0, 0, 0, 1, 0, 1);
        step(1, I_LD,  1, 1, 0, 0, 0, 1, 0, 1);
        step(1, I_LD,  2, 0, 0, 0, 1, 1, 0, 1);
        step(1, I_LD,  3, 0, 0, 0, 1, 1, 0, 1);
        step(1, I_LD,  4, 0, 0, 0, 0, 1, 0, 1);
        step(1, I_LD,  4, 0, 0, 0, 0, 1, 0, 1);
        step(1, I_LD,  5, 0, 1, 1, 1, 1, 0, 1);
        step(1, I_ST,  1, 0, 0, 0, 0, 1, 0, 2);
        step(1, I_ST,  1, 1, 0, 0, 0, 1, 0, 2);
        step(1, I_ST,  2, 0, 0, 0, 1, 1, 0, 2);
        step(1, I_ST,  3, 0, 0, 0, 1, 1, 0, 2);
        step(1, I_ST,  4, 0, 0, 0, 1, 0, 0, 2);
        step(0, I_ST,  4, 0, 1, 0, 1, 0, 0, 2);
        step(0, I_ST,  0, 0, 0, 0, 1, 1, 0, 3);

        // beq then nop; run drops during the nop's fetch and only acts at its retire
        pulse_reset("reset before beq");
        step(1, I_BEQ, 0, 0, 0, 0, 1, 1, 0, 0);
        step(1, I_BEQ, 1, 0, 0, 0, 0, 1, 0, 0);
        step(1, I_BEQ, 1, 1, 0, 0, 0, 1, 0, 0);
        step(1, I_BEQ, 2, 0, 0, 0, 1, 1, 0, 0);
        step(1, I_BEQ, 3, 0, 1, 0, 1, 1, 0, 0);
        step(0, I_NOP, 1, 0, 0, 0, 0, 1, 0, 1);
        step(0, I_NOP, 1, 1, 0, 0, 0, 1, 0, 1);
        step(0, I_NOP, 2, 0, 0, 0, 1, 1, 0, 1);
        step(0, I_NOP, 3, 0, 1, 0, 1, 1, 0, 1);
        step(0, I_NOP, 0, 0, 0, 0, 1, 1, 0, 2);
        step(0, I_NOP, 0, 0, 0, 0, 1, 1, 0, 2);

        // illegal class 111 traps; run toggling is ignored and the count freezes
        step(1, I_TRP, 0, 0, 0, 0, 1, 1, 0, 2);
        step(1, I_TRP, 1, 0, 0, 0, 0, 1, 0, 2);
        step(1, I_TRP, 1, 1, 0, 0, 0, 1, 0, 2);
        step(1, I_TRP, 2, 0, 0, 0, 1, 1, 0, 2);
        for (int i = 0; i < 20; i++) begin
            step(logic'(i % 2), I_TRP, 7, 0, 0, 0, 1, 1, 1, 2);
        end
        pulse_reset("reset out of trap");

        // control transfer with sub-op 101 is the first illegal one
        step(1, I_BAD, 0, 0, 0, 0, 1, 1, 0, 0);
        step(1, I_BAD, 1, 0, 0, 0, 0, 1, 0, 0);
        step(1, I_BAD, 1, 1, 0, 0, 0, 1, 0, 0);
        step(1, I_BAD, 2, 0, 0, 0, 1, 1, 0, 0);
        step(0, I_BAD, 7, 0, 0, 0, 1, 1, 1, 0);
        step(1, I_BAD, 7, 0, 0, 0, 1, 1, 1, 0);
        pulse_reset("reset out of bad trap");

        // jal writes back; jr (sub-op 100, last legal) retires in EXECUTE
        step(1, I_JAL, 0, 0, 0, 0, 1, 1, 0, 0);
        step(1, I_JAL, 1, 0, 0, 0, 0, 1, 0, 0);
        step(1, I_JAL, 1, 1, 0, 0, 0, 1, 0, 0);
        step(1, I_JAL, 2, 0, 0, 0, 1, 1, 0, 0);
        step(1, I_JAL, 3, 0, 0, 0, 1, 1, 0, 0);
        step(1, I_JAL, 5, 0, 1, 1, 1, 1, 0, 0);
        step(1, I_JR,  1, 0, 0, 0, 0, 1, 0, 1);
        step(1, I_JR,  1, 1, 0, 0, 0, 1, 0, 1);
        step(1, I_JR,  2, 0, 0, 0, 1, 1, 0, 1);
        step(0, I_JR,  3, 0, 1, 0, 1, 1, 0, 1);
        step(1, I_ST,  0, 0, 0, 0, 1, 1, 0, 2);

        // store interrupted by reset in its first MEMORY cycle
        step(1, I_ST,  1, 0, 0, 0, 0, 1, 0, 2);
        step(1, I_ST,  1, 1, 0, 0, 0, 1, 0, 2);
        step(1, I_ST,  2, 0, 0, 0, 1, 1, 0, 2);
        step(0, I_ST,  3, 0, 0, 0, 1, 1, 0, 2);
        push(1'b0, 3'd4, 0, 0, 0, 1, 0, 0, 16'd2);
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("mid-memory reset memWriteGate", 32'(memWriteGate), 32'd1);
        chk("mid-memory reset stage", 32'(stage), 32'd0);
        chk("mid-memory reset instrCount", 32'(instrCount), 32'd0);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        step(0, I_ST,  0, 0, 0, 0, 1, 1, 0, 0);

        // MEM_WAIT=0 instance: load in 5 cycles, irWrite and gate in the same cycle
        step0(1, I_LD, 0, 0, 0, 0, 1, 1, 0, 0);
        step0(1, I_LD, 1, 1, 0, 0, 0, 1, 0, 0);
        step0(1, I_LD, 2, 0, 0, 0, 1, 1, 0, 0);
        step0(1, I_LD, 3, 0, 0, 0, 1, 1, 0, 0);
        step0(1, I_LD, 4, 0, 0, 0, 0, 1, 0, 0);
        step0(0, I_LD, 5, 0, 1, 1, 1, 1, 0, 0);
        step0(0, I_LD, 0, 0, 0, 0, 1, 1, 0, 1);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(posedge clock);
        end
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending records expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
